fib_seq_ctrl: RTL and testbench
===============================

# fib_seq_ctrl

Control FSM for the Fibonacci engine: sequences the 5-bit step counter (`cntup`/`clr` inputs of the counter) and the two-register A/B adder datapath to compute F(n) for a requested n. The module sits between the top-level start/result handshake and the datapath. Each iteration is a compare/step pair: the counter value is compared against the latched n, and the datapath is advanced. The controller reports completion, a result-load strobe, and adder overflow.

## Interface
Parameters:
- `CNT_W`, default 5: width of the step counter and of n.

Ports:
- `clk` input 1: system clock; all state changes occur on its rising edge.
- `clr` input 1: reset; synchronous, active-high; forces IDLE.
- `start` input 1: request a computation; sampled only in IDLE.
- `n` input CNT_W: index of the requested Fibonacci term; latched when `start` is accepted.
- `abort` input 1: cancel the current computation; returns to IDLE without `done`.
- `cnt_val` input CNT_W: current step-counter value (counter `res`).
- `ovf` input 1: combinational carry-out of the datapath A+B adder.
- `cnt_up` output 1: counter increment enable.
- `cnt_clr` output 1: counter synchronous clear.
- `dp_init` output 1: datapath load, A<=0, B<=1.
- `dp_step` output 1: datapath advance, A<=B, B<=A+B.
- `res_ld` output 1: load the output register from A.
- `ready` output 1: high in IDLE only.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: one-cycle pulse, coincident with `done`, when the computation is aborted by overflow.

## Operation
- States: IDLE, INIT, CHECK, STEP, DONE, ERR. All outputs are Moore outputs decoded from state only.
- Output decode by state:
  - IDLE: `ready`=1.
  - INIT: `cnt_clr`=1, `dp_init`=1.
  - CHECK: all outputs 0.
  - STEP: `cnt_up`=1, `dp_step`=1.
  - DONE: `done`=1, `res_ld`=1.
  - ERR: `done`=1, `err`=1, `res_ld`=0.
- Transitions:
  - IDLE -> INIT when `start`=1; `n` is captured into `n_q` on the same edge.
  - INIT -> CHECK.
  - CHECK -> DONE if `cnt_val`==`n_q`; otherwise CHECK -> STEP.
  - STEP -> ERR if `ovf`=1 in that cycle; otherwise STEP -> CHECK.
  - DONE -> IDLE and ERR -> IDLE, unconditionally.
- Invariant at CHECK: A=F(`cnt_val`) and B=F(`cnt_val`+1). Result is A, so n=0 gives 0 and n=1 gives 1.
- `abort`=1 in INIT, CHECK or STEP forces IDLE on the next edge; no `done` is issued. `abort` in IDLE, DONE or ERR has no effect.
- Priority: `clr` > `abort` > normal transition.
- `start` outside IDLE is ignored; the request is not queued.
- Changes on `n` after acceptance have no effect (`n_q` is held).
- Comparison is unsigned, full CNT_W bits. n=31 is legal; the counter never wraps, because the match occurs before increment 32.
- On `ovf`, the datapath may hold a corrupted B; the output register is not loaded.

## Timing
- Reset values: state=IDLE, `n_q`=0, `ready`=1; all other outputs 0.
- `start` sampled at edge k:
  - INIT during cycle k+1.
  - First CHECK during cycle k+2.
  - `done`/`res_ld` during cycle k+3+2n.
  - `ready` returns during cycle k+4+2n.
- Each iteration takes 2 cycles (CHECK, STEP). The counter and datapath update at the end of the STEP cycle, so CHECK always sees post-increment `cnt_val`.
- Back-to-back: `start` held high through DONE is accepted on the first IDLE cycle. Minimum gap between `done` pulses is 2n+4 cycles.
- `clr` asserted mid-operation: IDLE on the next edge; outputs return to reset values in the following cycle. `cnt_clr` is not asserted by reset; the counter shares `clr` at the top level.

## Structure
- Shared include `fib_defs.vh`:
  - State encodings (3-bit binary: IDLE=0, INIT=1, CHECK=2, STEP=3, DONE=4, ERR=5).
  - `CNT_W` default.
  - Datapath width constant used by the adder.
- Single module, no sub-module: state register, `n_q` register, next-state logic and output decoder.
- The counter and the A/B datapath are separate instances wired at the top level.
- Unused encodings 6 and 7 decode to IDLE on the next edge.

## Test plan
- Reset: `clr`=1 for 2 cycles, then 0. Expect `ready`=1, all other outputs 0, state IDLE.
- n=0: `start` pulse at edge k. Expect `dp_init` at k+1, `done`/`res_ld` at k+3, no `cnt_up`, result 0.
- n=10: with counter and datapath models attached. Expect exactly 10 `cnt_up` pulses, `done` at k+23, A=55, `err`=0.
- Abort: n=20; assert `abort` on the 3rd STEP cycle. Expect IDLE next cycle, no `done`. A following `start` with n=2 gives result 1.
- Overflow: 8-bit datapath model, n=20. `ovf` rises at the step producing F(14)=377. Expect a single cycle with `done`=1, `err`=1, `res_ld`=0, then IDLE.
- Ignored start and n change: `start` pulsed while busy, and `n` changed from 5 to 9 after acceptance. Expect a single `done` at k+13 with result 5.

Source files
------------

// File: rtl/fib_seq_ctrl_pkg.sv
// Shared definitions for the Fibonacci engine controller: state encodings,
// default widths and the Moore output decode table.
package fib_seq_ctrl_pkg;

  // Default width of the step counter and of the requested index n.
  localparam int CNT_W_DEF = 5;

  // Width of the A/B adder datapath driven by this controller.
  localparam int DP_W = 32;

  // 3-bit binary state encoding; 6 and 7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_CHECK = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Bundle of every controller output, decoded from state alone.
  typedef struct packed {
    logic cnt_up;
    logic cnt_clr;
    logic dp_init;
    logic dp_step;
    logic res_ld;
    logic ready;
    logic done;
    logic err;
  } ctrl_out_t;

  // Moore output table; unused encodings decode to all-zero outputs.
  function automatic ctrl_out_t decode_outputs(input state_t s);
    ctrl_out_t o;
    o = '0;
    case (s)
      ST_IDLE:  o.ready = 1'b1;
      ST_INIT: begin
        o.cnt_clr = 1'b1;
        o.dp_init = 1'b1;
      end
      ST_CHECK: o = '0;
      ST_STEP: begin
        o.cnt_up  = 1'b1;
        o.dp_step = 1'b1;
      end
      ST_DONE: begin
        o.done   = 1'b1;
        o.res_ld = 1'b1;
      end
      ST_ERR: begin
        o.done = 1'b1;
        o.err  = 1'b1;
      end
      default:  o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/fib_seq_ctrl.sv
// Control FSM for the Fibonacci engine. Walks the step counter and the A/B
// datapath through compare/step iterations until the counter equals the
// latched n, then strobes the result load (or flags adder overflow).
//
// Handshake: start is a request sampled only while ready=1 (IDLE); it is
// accepted on the rising edge where start=1 and ready=1, n is captured on that
// same edge, and completion is signalled by a one-cycle done pulse (with err
// when the result was lost to overflow). Requests while busy are dropped.
module fib_seq_ctrl
  import fib_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [CNT_W-1:0] n,
  input  logic             abort,
  input  logic [CNT_W-1:0] cnt_val,
  input  logic             ovf,
  output logic             cnt_up,
  output logic             cnt_clr,
  output logic             dp_init,
  output logic             dp_step,
  output logic             res_ld,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [2:0]       dbg_state
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  ctrl_out_t        outs;
  logic             busy;

  // Abort only matters while a computation is in flight.
  assign busy = (state_q == ST_INIT) || (state_q == ST_CHECK) ||
                (state_q == ST_STEP);

  // State and latched-n registers; clr has top priority.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  // Next-state logic: abort overrides the normal walk through the iteration.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    if (abort && busy) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_INIT;
            n_d     = n;
          end
        end
        ST_INIT:  state_d = ST_CHECK;
        ST_CHECK: state_d = (cnt_val == n_q) ? ST_DONE : ST_STEP;
        ST_STEP:  state_d = ovf ? ST_ERR : ST_CHECK;
        ST_DONE:  state_d = ST_IDLE;
        ST_ERR:   state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode from state only.
  always_comb begin
    outs = decode_outputs(state_q);
  end

  assign cnt_up    = outs.cnt_up;
  assign cnt_clr   = outs.cnt_clr;
  assign dp_init   = outs.dp_init;
  assign dp_step   = outs.dp_step;
  assign res_ld    = outs.res_ld;
  assign ready     = outs.ready;
  assign done      = outs.done;
  assign err       = outs.err;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl with behavioural counter, A/B datapath and
// result register attached.
module tb_fib_seq_ctrl;

  localparam int CNT_W = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             clr, start, abort;
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             cnt_up, cnt_clr, dp_init, dp_step, res_ld, ready, done, err;
  logic [2:0]       dbg_state;

  fib_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .n         (n),
    .abort     (abort),
    .cnt_val   (cnt),
    .ovf       (ovf),
    .cnt_up    (cnt_up),
    .cnt_clr   (cnt_clr),
    .dp_init   (dp_init),
    .dp_step   (dp_step),
    .res_ld    (res_ld),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- environment models ----------------
  logic        dp_w8;
  logic [31:0] a, b, res_q;
  logic [32:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};
  assign ovf = dp_w8 ? sum[8] : sum[32];

  always @(posedge clk) begin
    if (clr || cnt_clr) cnt <= '0;
    else if (cnt_up)    cnt <= cnt + 1'b1;
  end

  always @(posedge clk) begin
    if (clr) begin
      a <= '0;
      b <= '0;
    end else if (dp_init) begin
      a <= 32'd0;
      b <= 32'd1;
    end else if (dp_step) begin
      a <= b;
      b <= dp_w8 ? {24'd0, sum[7:0]} : sum[31:0];
    end
  end

  always @(posedge clk) begin
    if (clr)         res_q <= '0;
    else if (res_ld) res_q <= a;
  end

  // ---------------- cycle counting and monitor ----------------
  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int cyc, up_cnt, done_cnt, err_cnt, resld_at_done, init_cyc, first_done, last_done;

  always @(negedge clk) begin
    cyc = edges + 1;
    if (cnt_up) up_cnt++;
    if (dp_init && init_cyc == 0) init_cyc = cyc;
    if (done) begin
      done_cnt++;
      if (first_done == 0) first_done = cyc;
      last_done = cyc;
      if (err) err_cnt++;
      if (res_ld) resld_at_done++;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    up_cnt = 0; done_cnt = 0; err_cnt = 0; resld_at_done = 0;
    init_cyc = 0; first_done = 0; last_done = 0;
  endtask

  // Pulse start for one edge; k is the index of the accepting edge.
  task automatic issue_start(input int nv, output int k);
    @(negedge clk);
    start = 1'b1;
    n     = nv[CNT_W-1:0];
    @(posedge clk);
    #1;
    k     = edges;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) break;
      @(posedge clk);
    end
    check("done_timeout", (done_cnt > 0) ? 1 : 0, 1);
  endtask

  task automatic wait_edge(input int e);
    for (int i = 0; i < 200; i++) begin
      if (edges >= e) break;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int other_outs();
    return {25'd0, cnt_up, cnt_clr, dp_init, dp_step, res_ld, done, err};
  endfunction

  // ---------------- stimulus ----------------
  int k;

  initial begin
    clr = 1'b1; start = 1'b0; abort = 1'b0; n = '0; dp_w8 = 1'b0;
    clear_mon();

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_state", dbg_state, 0);
    check("rst_outs", other_outs(), 0);
    clr = 1'b0;
    @(negedge clk);
    check("post_rst_ready", ready, 1);
    check("post_rst_outs", other_outs(), 0);

    // n = 0
    clear_mon();
    issue_start(0, k);
    wait_done(20);
    check("n0_init_cyc", init_cyc, k + 1);
    check("n0_done_cyc", first_done, k + 3);
    check("n0_cnt_up", up_cnt, 0);
    check("n0_err", err_cnt, 0);
    @(negedge clk);
    check("n0_ready_back", ready, 1);
    check("n0_result", res_q, 0);

    // n = 10
    clear_mon();
    issue_start(10, k);
    wait_done(60);
    check("n10_done_cyc", first_done, k + 23);
    check("n10_cnt_up", up_cnt, 10);
    check("n10_err", err_cnt, 0);
    check("n10_res_ld", resld_at_done, 1);
    @(negedge clk);
    check("n10_ready_back", ready, 1);
    check("n10_result", res_q, 55);

    // Abort on the 3rd STEP cycle (cycle k+7)
    clear_mon();
    issue_start(20, k);
    wait_edge(k + 6);
    abort = 1'b1;
    @(negedge clk);
    check("abort_in_step", dbg_state, 3);
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_state", dbg_state, 0);
    check("abort_ready", ready, 1);
    repeat (50) @(posedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_cnt_up", up_cnt, 3);
    clear_mon();
    issue_start(2, k);
    wait_done(20);
    check("after_abort_done_cyc", first_done, k + 7);
    @(negedge clk);
    check("after_abort_result", res_q, 1);

    // Overflow with 8-bit datapath
    dp_w8 = 1'b1;
    clear_mon();
    issue_start(20, k);
    wait_done(80);
    check("ovf_done_cyc", first_done, k + 28);
    check("ovf_err", err_cnt, 1);
    check("ovf_res_ld", resld_at_done, 0);
    @(negedge clk);
    check("ovf_ready_back", ready, 1);
    check("ovf_result_held", res_q, 1);
    repeat (5) @(posedge clk);
    check("ovf_single_done", done_cnt, 1);
    dp_w8 = 1'b0;

    // Ignored start and n change while busy
    clear_mon();
    issue_start(5, k);
    wait_edge(k + 3);
    n     = 5'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(40);
    check("ign_done_cyc", first_done, k + 13);
    @(negedge clk);
    check("ign_result", res_q, 5);
    repeat (20) @(posedge clk);
    check("ign_single_done", done_cnt, 1);

    // Back-to-back: start held high, n = 1
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    n     = 5'd1;
    @(posedge clk);
    #1;
    k = edges;
    for (int i = 0; i < 40; i++) begin
      if (done_cnt >= 2) break;
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    check("b2b_first_done", first_done, k + 5);
    check("b2b_gap", last_done - first_done, 6);
    repeat (10) @(posedge clk);
    check("b2b_done_count", done_cnt, 2);

    // clr mid-operation
    clear_mon();
    issue_start(10, k);
    repeat (5) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_state", dbg_state, 0);
    check("clr_ready", ready, 1);
    check("clr_outs", other_outs(), 0);
    repeat (30) @(posedge clk);
    check("clr_no_done", done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
